// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message sequencer.
package sha256_pkg;

  localparam int BLOCK_W = 512;
  localparam int HASH_W  = 256;
  localparam int COUNT_W = 16;
  localparam int TIMER_W = 8;

  // SHA-256 initial hash value H0..H7, H0 in the most significant word.
  localparam logic [HASH_W-1:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } state_t;

  // Block counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/sha256_timeout_ctr.sv
// Core-response watchdog: cleared while a block is issued, counts each
// cycle spent waiting, and flags the cycle whose count reaches the limit.
module sha256_timeout_ctr
  import sha256_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  // expired is high during the waiting cycle whose closing edge would
  // bring the count to limit, so the owner acts on that same edge.
  assign expired = en && (count == limit - 1'b1);

  // Wait-cycle counter; holds once expired so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sha256_msg_ctrl.sv
// Multi-block message sequencer for the SHA-256 compression core: accepts
// padded blocks, chains each block's hash into the next, and emits the
// final digest with a one-cycle pulse. A silent core raises a sticky error.
module sha256_msg_ctrl
  import sha256_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 127
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [HASH_W-1:0]  iv,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [BLOCK_W-1:0] blk_data,
  input  logic               blk_last,
  output logic [HASH_W-1:0]  core_H_in,
  output logic [BLOCK_W-1:0] core_M_in,
  output logic               core_input_valid,
  input  logic [HASH_W-1:0]  core_H_out,
  input  logic               core_output_valid,
  output logic [HASH_W-1:0]  digest,
  output logic               digest_valid,
  output logic               busy,
  output logic [COUNT_W-1:0] blk_count,
  output logic               err
);

  localparam logic [TIMER_W-1:0] TIMEOUT_LIMIT = TIMER_W'(TIMEOUT_CYCLES);

  state_t              state;
  logic                first;
  logic                last;
  logic [HASH_W-1:0]   chain;
  logic                timer_clear;
  logic                timer_en;
  logic                expired;

  // Ready is decoded from state; it also reads high while reset is held,
  // but the reset branch below prevents any transfer in that case.
  assign blk_ready   = (state == ST_IDLE) || !rst;
  assign timer_clear = (state == ST_ISSUE);
  assign timer_en    = (state == ST_WAIT);

  sha256_timeout_ctr #(
    .W(TIMER_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .en      (timer_en),
    .limit   (TIMEOUT_LIMIT),
    .expired (expired)
  );

  // Message sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the wide datapath registers are reset too, so the core and
      // the digest port never present stale data from an aborted message.
      state            <= ST_IDLE;
      first            <= 1'b1;
      last             <= 1'b0;
      chain            <= '0;
      digest           <= '0;
      core_H_in        <= '0;
      core_M_in        <= '0;
      core_input_valid <= 1'b0;
      digest_valid     <= 1'b0;
      busy             <= 1'b0;
      err              <= 1'b0;
      blk_count        <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values; the pulse defaults below are overridden later.
      core_input_valid <= 1'b0;
      digest_valid     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (blk_valid) begin
            core_M_in        <= blk_data;
            core_H_in        <= first ? iv : chain;
            last             <= blk_last;
            core_input_valid <= 1'b1;
            busy             <= 1'b1;
            state            <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          // A response on the expiry edge takes priority over the timeout.
          if (core_output_valid) begin
            chain     <= core_H_out;
            blk_count <= sat_inc(blk_count);
            if (last) begin
              digest       <= core_H_out;
              digest_valid <= 1'b1;
              state        <= ST_FINISH;
            end else begin
              first <= 1'b0;
              state <= ST_IDLE;
            end
          end else if (expired) begin
            err       <= 1'b1;
            first     <= 1'b1;
            blk_count <= '0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        ST_FINISH: begin
          first     <= 1'b1;
          blk_count <= '0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Directed bench for sha256_msg_ctrl. A behavioural SHA-256 compression
// function stands in for the core; final digests are the published vectors.
module tb_sha256_msg_ctrl;
  import sha256_pkg::*;

  localparam int TO = 8;

  localparam logic [511:0] BLK_ABC = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] BLK_2A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_2B = {448'h0, 64'h1c0};
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_2 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] iv_val;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;
  logic [255:0] core_H_in;
  logic [511:0] core_M_in;
  logic         core_input_valid;
  logic [255:0] core_H_out;
  logic         core_output_valid;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;
  logic [15:0]  blk_count;
  logic         err;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected controller-visible state kept by the bench.
  logic         exp_first;
  logic [255:0] exp_chain;
  logic [15:0]  exp_count;
  logic [255:0] exp_hin;
  logic [511:0] exp_m;
  logic [255:0] exp_res;

  always #5 clk = ~clk;

  sha256_msg_ctrl #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .iv                (iv_val),
    .blk_valid         (blk_valid),
    .blk_ready         (blk_ready),
    .blk_data          (blk_data),
    .blk_last          (blk_last),
    .core_H_in         (core_H_in),
    .core_M_in         (core_M_in),
    .core_input_valid  (core_input_valid),
    .core_H_out        (core_H_out),
    .core_output_valid (core_output_valid),
    .digest            (digest),
    .digest_valid      (digest_valid),
    .busy              (busy),
    .blk_count         (blk_count),
    .err               (err)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One SHA-256 compression including the final H addition.
  function automatic logic [255:0] sha256_compress(input logic [255:0] h_in, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = h_in;
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {h_in[255:224] + a, h_in[223:192] + b, h_in[191:160] + c, h_in[159:128] + d,
            h_in[127:96] + e,  h_in[95:64] + f,   h_in[63:32] + g,   h_in[31:0] + h};
  endfunction

  task automatic check(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, blk_ready, 1'b1);
    check({tag, "_civ"}, core_input_valid, 1'b0);
    check({tag, "_dv"}, digest_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_count"}, blk_count, 16'd0);
    check({tag, "_digest"}, digest, 256'd0);
    check({tag, "_hin"}, core_H_in, 256'd0);
    check({tag, "_min"}, core_M_in, 512'd0);
  endtask

  // Present a block in IDLE and check the ISSUE cycle. With hold set,
  // blk_valid stays high and the next block is placed on the bus at once.
  task automatic issue_block(input logic [511:0] data, input logic lst, input logic hold,
                             input logic [511:0] nxt_data, input logic nxt_last);
    blk_valid = 1'b1;
    blk_data  = data;
    blk_last  = lst;
    check("ready_before_accept", blk_ready, 1'b1);
    exp_hin = exp_first ? SHA256_IV : exp_chain;
    exp_m   = data;
    exp_res = sha256_compress(exp_hin, data);
    @(negedge clk);
    if (hold) begin
      blk_data = nxt_data;
      blk_last = nxt_last;
    end else begin
      blk_valid = 1'b0;
    end
    check("issue_civ", core_input_valid, 1'b1);
    check("issue_hin", core_H_in, exp_hin);
    check("issue_min", core_M_in, exp_m);
    check("issue_busy", busy, 1'b1);
    check("issue_ready", blk_ready, 1'b0);
  endtask

  // Let the core answer in WAIT cycle lat, then check the following cycles.
  task automatic respond(input int lat, input logic lst);
    @(negedge clk);
    check("wait_civ_low", core_input_valid, 1'b0);
    for (int i = 2; i <= lat; i++) @(negedge clk);
    check("wait_ready", blk_ready, 1'b0);
    check("wait_hin_stable", core_H_in, exp_hin);
    check("wait_min_stable", core_M_in, exp_m);
    core_H_out        = exp_res;
    core_output_valid = 1'b1;
    @(negedge clk);
    core_output_valid = 1'b0;
    core_H_out        = '1;
    exp_chain = exp_res;
    exp_count = exp_count + 16'd1;
    if (!lst) begin
      exp_first = 1'b0;
      check("mid_ready", blk_ready, 1'b1);
      check("mid_count", blk_count, exp_count);
      check("mid_busy", busy, 1'b1);
      check("mid_dv", digest_valid, 1'b0);
    end else begin
      check("fin_dv", digest_valid, 1'b1);
      check("fin_digest", digest, exp_res);
      check("fin_ready", blk_ready, 1'b0);
      check("fin_count", blk_count, exp_count);
      check("fin_busy", busy, 1'b1);
      @(negedge clk);
      exp_first = 1'b1;
      exp_count = 16'd0;
      check("post_dv", digest_valid, 1'b0);
      check("post_ready", blk_ready, 1'b1);
      check("post_busy", busy, 1'b0);
      check("post_count", blk_count, exp_count);
      check("post_civ", core_input_valid, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst               = 1'b0;
    iv_val            = SHA256_IV;
    blk_valid         = 1'b0;
    blk_data          = '0;
    blk_last          = 1'b0;
    core_H_out        = '1;
    core_output_valid = 1'b0;
    exp_first         = 1'b1;
    exp_chain         = '0;
    exp_count         = 16'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    @(negedge clk);

    // Single-block "abc".
    issue_block(BLK_ABC, 1'b1, 1'b0, '0, 1'b0);
    respond(3, 1'b1);
    check("abc_digest", digest, DIG_ABC);

    // Two-block message; second answer arrives on the timeout edge.
    issue_block(BLK_2A, 1'b0, 1'b0, '0, 1'b0);
    respond(1, 1'b0);
    issue_block(BLK_2B, 1'b1, 1'b0, '0, 1'b0);
    respond(TO, 1'b1);
    check("two_digest", digest, DIG_2);
    check("two_no_err", err, 1'b0);

    // Back-to-back messages with blk_valid held high throughout.
    issue_block(BLK_ABC, 1'b1, 1'b1, BLK_2A, 1'b0);
    respond(2, 1'b1);
    check("b2b_abc_digest", digest, DIG_ABC);
    issue_block(BLK_2A, 1'b0, 1'b1, BLK_2B, 1'b1);
    respond(2, 1'b0);
    issue_block(BLK_2B, 1'b1, 1'b0, '0, 1'b0);
    respond(2, 1'b1);
    check("b2b_two_digest", digest, DIG_2);

    // Core goes silent on block 2: error after exactly TO wait cycles.
    issue_block(BLK_2A, 1'b0, 1'b0, '0, 1'b0);
    respond(3, 1'b0);
    issue_block(BLK_2B, 1'b1, 1'b0, '0, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      check("to_err_low", err, 1'b0);
    end
    @(negedge clk);
    exp_first = 1'b1;
    exp_count = 16'd0;
    check("to_err_set", err, 1'b1);
    check("to_ready", blk_ready, 1'b1);
    check("to_busy", busy, 1'b0);
    check("to_count", blk_count, 16'd0);
    check("to_no_dv", digest_valid, 1'b0);
    @(negedge clk);
    check("to_no_dv_late", digest_valid, 1'b0);
    issue_block(BLK_ABC, 1'b1, 1'b0, '0, 1'b0);
    respond(4, 1'b1);
    check("after_to_digest", digest, DIG_ABC);
    check("after_to_err_sticky", err, 1'b1);

    // Reset pulse while block 1 of the two-block message is in WAIT.
    issue_block(BLK_2A, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    rst = 1'b1;
    exp_first = 1'b1;
    exp_count = 16'd0;
    core_H_out        = {8{32'hdeadbeef}};
    core_output_valid = 1'b1;
    @(negedge clk);
    core_output_valid = 1'b0;
    core_H_out        = '1;
    check("spurious_count", blk_count, 16'd0);
    check("spurious_dv", digest_valid, 1'b0);
    check("spurious_digest", digest, 256'd0);
    check("spurious_busy", busy, 1'b0);
    check("spurious_ready", blk_ready, 1'b1);
    issue_block(BLK_ABC, 1'b1, 1'b0, '0, 1'b0);
    respond(3, 1'b1);
    check("after_reset_digest", digest, DIG_ABC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
